// File: rtl/mc_ctrl.sv
// -----------------------------------------------------------------------------
// mc_ctrl -- multi-cycle main controller for the MIPS datapath.
//
// Sequences each instruction through IF/ID/EX/MEM/WB and drives every datapath
// write enable and mux select. The state is registered. The enables and
// selects are decoded combinationally from the current state, op, funct and
// zero. While reset is high, every enable and select is forced to 0.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high
//   op[5:0]    in   IR[31:26], stable from ID onward
//   funct[5:0] in   IR[5:0]
//   zero       in   ALU equality flag, used only by beq in EX
//   mem_ready  in   data memory completes the access this cycle (MEM only)
//   pc_we, ir_we, reg_we, mem_re, mem_we              out  enables
//   ext_op, alu_src, alu_op[2:0], reg_dst[1:0],
//   wd_sel[1:0], npc_sel[1:0]                         out  datapath selects
//   state[2:0] out  current state (IF=0 ID=1 EX=2 MEM=3 WB=4)
//   illegal    out  one-cycle pulse in ID on an undecoded instruction
//
// Optional feature macro: MC_CTRL_PERF_EN
//   This macro adds the instr_cnt[31:0] output, which counts retired legal
//   instructions. It also adds the stall_cnt[31:0] output, which counts MEM
//   wait cycles.
// -----------------------------------------------------------------------------
module mc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_we,
  output logic        ir_we,
  output logic        reg_we,
  output logic        mem_re,
  output logic        mem_we,
  output logic        ext_op,
  output logic        alu_src,
  output logic [2:0]  alu_op,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wd_sel,
  output logic [1:0]  npc_sel,
  output logic [2:0]  state,
  output logic        illegal
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0] instr_cnt,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_NOP   = 6'b000000;

  state_e     state_q, state_d;
  logic       is_rtype_s, is_addu_s, is_subu_s, is_jr_s, is_nop_s;
  logic       is_ori_s, is_lui_s, is_lw_s, is_sw_s, is_beq_s, is_j_s, is_jal_s;
  logic       legal_s, ext_sel_s, alu_src_sel_s;
  logic [2:0] alu_op_sel_s;

  assign state = state_q;

  // Instruction decode and the selects that depend only on the instruction.
  always_comb begin
    is_rtype_s = (op == OP_RTYPE);
    is_addu_s  = is_rtype_s && (funct == FN_ADDU);
    is_subu_s  = is_rtype_s && (funct == FN_SUBU);
    is_jr_s    = is_rtype_s && (funct == FN_JR);
    is_nop_s   = is_rtype_s && (funct == FN_NOP);
    is_ori_s   = (op == OP_ORI);
    is_lui_s   = (op == OP_LUI);
    is_lw_s    = (op == OP_LW);
    is_sw_s    = (op == OP_SW);
    is_beq_s   = (op == OP_BEQ);
    is_j_s     = (op == OP_J);
    is_jal_s   = (op == OP_JAL);
    legal_s    = is_addu_s | is_subu_s | is_jr_s | is_nop_s | is_ori_s | is_lui_s |
                 is_lw_s | is_sw_s | is_beq_s | is_j_s | is_jal_s;
    ext_sel_s     = is_ori_s | is_lui_s;
    alu_src_sel_s = is_ori_s | is_lui_s | is_lw_s | is_sw_s;
    if (is_subu_s || is_beq_s) begin
      alu_op_sel_s = 3'd1;
    end else if (is_ori_s) begin
      alu_op_sel_s = 3'd2;
    end else if (is_lui_s) begin
      alu_op_sel_s = 3'd3;
    end else begin
      alu_op_sel_s = 3'd0;
    end
  end

  // Enables and selects for the current state. All of them are 0 while reset is high.
  always_comb begin
    pc_we   = 1'b0;
    ir_we   = 1'b0;
    reg_we  = 1'b0;
    mem_re  = 1'b0;
    mem_we  = 1'b0;
    ext_op  = 1'b0;
    alu_src = 1'b0;
    alu_op  = 3'd0;
    reg_dst = 2'd0;
    wd_sel  = 2'd0;
    npc_sel = 2'd0;
    illegal = 1'b0;
    if (!reset) begin
      // The instruction selects stay valid from ID through WB.
      if (state_q != S_IF) begin
        ext_op  = ext_sel_s;
        alu_src = alu_src_sel_s;
        alu_op  = alu_op_sel_s;
      end else begin
        ir_we = 1'b1;
        pc_we = 1'b1;
      end
      case (state_q)
        S_ID: begin
          if (is_j_s || is_jal_s) begin
            pc_we   = 1'b1;
            npc_sel = 2'd2;
          end else if (is_jr_s) begin
            pc_we   = 1'b1;
            npc_sel = 2'd3;
          end else begin
            pc_we   = 1'b0;
          end
          illegal = !legal_s;
        end
        S_EX: begin
          if (is_beq_s) begin
            pc_we   = zero;
            npc_sel = 2'd1;
          end else begin
            pc_we   = 1'b0;
          end
        end
        S_MEM: begin
          mem_re = is_lw_s;
          mem_we = is_sw_s;
        end
        S_WB: begin
          reg_we = 1'b1;
          if (is_jal_s) begin
            reg_dst = 2'd2;
            wd_sel  = 2'd2;
          end else if (is_rtype_s) begin
            reg_dst = 2'd1;
          end else begin
            reg_dst = 2'd0;
            wd_sel  = is_lw_s ? 2'd1 : 2'd0;
          end
        end
        default: begin
          npc_sel = 2'd0;
        end
      endcase
    end else begin
      illegal = 1'b0;
    end
  end

  // Next-state sequencing per instruction path.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        if (is_j_s || is_jr_s || is_nop_s || !legal_s) begin
          state_d = S_IF;
        end else if (is_jal_s) begin
          state_d = S_WB;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        if (is_beq_s) begin
          state_d = S_IF;
        end else if (is_lw_s || is_sw_s) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        // An opcode other than lw/sw cannot reach MEM. If one does, the state recovers to IF.
        if (!(is_lw_s || is_sw_s)) begin
          state_d = S_IF;
        end else if (mem_ready) begin
          state_d = is_lw_s ? S_WB : S_IF;
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB:    state_d = S_IF;
      default: state_d = S_IF;
    endcase
  end

  // State register; reset forces IF and abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IF;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef MC_CTRL_PERF_EN
  logic [31:0] instr_cnt_q, instr_cnt_d, stall_cnt_q, stall_cnt_d;

  assign instr_cnt = instr_cnt_q;
  assign stall_cnt = stall_cnt_q;

  // A legal instruction retires when the state returns to IF. An illegal instruction leaves through ID and is not counted.
  always_comb begin
    instr_cnt_d = instr_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if ((state_q != S_IF) && (state_d == S_IF) && !((state_q == S_ID) && !legal_s)) begin
      instr_cnt_d = instr_cnt_q + 32'd1;
    end else begin
      instr_cnt_d = instr_cnt_q;
    end
    if ((state_q == S_MEM) && !mem_ready) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Performance counter registers, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      instr_cnt_q <= instr_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
`endif

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle main controller for the MIPS datapath. It sequences PC, IR, GRF, ALU, immediate extender and data memory through IF/ID/EX/MEM/WB states, and drives every datapath select and write enable, including `ext_op` for the immediate extender. It sits between the IR fields and the datapath muxes, and stalls in MEM on a data-memory ready handshake.

## Interface
No parameters.
- `clk` input 1: clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `op` input 6: IR[31:26], stable from ID onward.
- `funct` input 6: IR[5:0].
- `zero` input 1: ALU equality flag (rs == rt), valid in EX.
- `mem_ready` input 1: data memory completes the access this cycle.
- `pc_we` output 1: PC write enable.
- `ir_we` output 1: IR write enable.
- `reg_we` output 1: GRF write enable.
- `mem_re` output 1: data memory read request.
- `mem_we` output 1: data memory write request.
- `ext_op` output 1: 0 = sign-extend, 1 = zero-extend.
- `alu_src` output 1: 0 = rt, 1 = extended immediate.
- `alu_op` output 3: 0 ADD, 1 SUB, 2 OR, 3 LUI (imm<<16).
- `reg_dst` output 2: 0 rt, 1 rd, 2 $31.
- `wd_sel` output 2: 0 ALU result, 1 memory data, 2 PC (link).
- `npc_sel` output 2: 0 PC+4, 1 branch target, 2 jump target, 3 rs.
- `state` output 3: current state, for debug.
- `illegal` output 1: one-cycle pulse on an undecoded instruction.

## Operation
- States: IF=0, ID=1, EX=2, MEM=3, WB=4.
- IF: `ir_we=1`, `pc_we=1`, `npc_sel=0`. Next state is ID.
- Decoded opcodes:
  - R-type (op 000000): addu funct 100001, subu 100011, jr 001000, nop funct 000000.
  - I-type and jumps: ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- Paths:
  - addu/subu/ori/lui: IF→ID→EX→WB→IF.
  - lw: IF→ID→EX→MEM→WB→IF.
  - sw: IF→ID→EX→MEM→IF.
  - beq: IF→ID→EX→IF. In EX, `pc_we=zero`, `npc_sel=1`.
  - j/jr: IF→ID→IF. In ID, `pc_we=1`, `npc_sel=2` for j or 3 for jr.
  - jal: IF→ID→WB→IF. In ID, `pc_we=1`, `npc_sel=2`. In WB, `reg_we=1`, `reg_dst=2`, `wd_sel=2`. The PC captured for the link is the return address, PC+4 of jal.
  - nop and illegal: IF→ID→IF, with no writes. Illegal pulses `illegal=1` in ID.
- Selects per instruction:
  - `ext_op`: 1 for ori/lui, 0 otherwise (lw/sw/beq).
  - `alu_src`: 1 for ori/lui/lw/sw.
  - `alu_op`: ADD for addu/lw/sw, SUB for subu/beq, OR for ori, LUI for lui.
- WB:
  - `reg_we=1`.
  - `reg_dst`: 1 for R-type, 0 for I-type, 2 for jal.
  - `wd_sel`: 1 for lw, 0 for ALU ops, 2 for jal.
- MEM:
  - Hold `mem_re` (lw) or `mem_we` (sw) high while `mem_ready=0`; stay in MEM.
  - Advance on the cycle `mem_ready=1`.
- All outputs are combinational from `state`, `op`, `funct` and `zero`. Selects not listed for a state are driven to 0.

## Timing
- Reset:
  - The cycle `reset=1` is sampled, `state` is forced to IF on that edge.
  - While `reset` is high, all enables are forced to 0: `pc_we`, `ir_we`, `reg_we`, `mem_re`, `mem_we`, `illegal`.
  - Selects reset to 0.
- Reset mid-instruction abandons it. No GRF or memory write occurs in the reset cycle, even if `mem_ready=1` in the same cycle.
- Latency with zero wait:
  - j/jr/nop: 2 cycles.
  - beq/jal: 3 cycles.
  - R-type/ori/lui/sw: 4 cycles.
  - lw: 5 cycles.
  - Each MEM wait cycle adds 1.
- `mem_ready` outside MEM is ignored.
- `zero` is sampled only in EX for beq.

## Configuration
- `MC_CTRL_PERF_EN` defined:
  - Adds output `instr_cnt` (32 bits): increments on every transition into IF from a non-IF state, excluding illegal instructions.
  - Adds output `stall_cnt` (32 bits): increments each MEM cycle with `mem_ready=0`.
  - Both counters reset to 0 and wrap modulo 2^32.
- Undefined: neither port nor counter logic exists. All other behaviour is identical.

## Test plan
- Reset, then ori (op 001101), `mem_ready=1`:
  - `state` sequence is 0,1,2,4,0.
  - `ext_op=1` and `alu_src=1` throughout ID/EX/WB.
  - WB has `reg_we=1`, `reg_dst=0`, `wd_sel=0`.
- lw (op 100011) with `mem_ready` low for 3 cycles in MEM:
  - Sequence 0,1,2,3,3,3,3,4,0.
  - `mem_re=1` for all four MEM cycles.
  - With perf enabled, `stall_cnt=3` and `instr_cnt=1`.
- beq with `zero=0`, then beq with `zero=1`:
  - EX `pc_we` is 0, then 1.
  - `npc_sel=1` in both EX cycles.
  - `ext_op=0`, `alu_op=1`.
- jal (op 000011):
  - ID has `pc_we=1`, `npc_sel=2`.
  - WB has `reg_we=1`, `reg_dst=2`, `wd_sel=2`.
  - Total 3 cycles.
- sw in MEM with `mem_we=1`, `reset=1` and `mem_ready=1` in the same cycle:
  - `mem_we` and `pc_we` are driven 0.
  - Next `state=0`.
- op 111111:
  - `illegal=1` for exactly one cycle, in ID.
  - No enables asserted.
  - Returns to IF after 2 cycles.
